nibble_serial_add_ctrl: RTL and testbench
=========================================

# nibble_serial_add_ctrl

Sequencer that computes a WIDTH-bit add by time-multiplexing a single 4-bit ripple adder over the operand nibbles, least-significant first, chaining carry between cycles. It sits in the arithmetic datapath as the controller for the shared 4-bit adder and trades latency for area. The block offers a start/busy/done handshake to the requesting logic and holds the result until the next accepted start.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4
- NIB, WIDTH/4, number of nibble steps (derived, not overridden)

- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- a  input  WIDTH  operand A; latched on the accepted start
- b  input  WIDTH  operand B; latched on the accepted start
- cin  input  1  carry-in to nibble 0; latched on the accepted start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse when the result becomes valid
- s  output  WIDTH  sum; holds the last completed result
- cout  output  1  carry out of the MSB nibble
- ovf  output  1  two's-complement overflow: carry into bit WIDTH-1 XOR cout

## Operation
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1, step counter 0..NIB-1.
  - DONE: busy=0, done=1.
- Transitions:
  - IDLE → RUN on start=1.
  - In RUN, the counter advances each cycle. RUN → DONE after the step where counter=NIB-1.
  - DONE → RUN on start=1. Otherwise DONE → IDLE.
- Accepted start actions:
  - Latch a, b and cin into internal registers.
  - Clear the counter and s, so partial results are never exposed as valid.
- RUN step k:
  - The adder sees a_r[4k+3:4k], b_r[4k+3:4k] and carry register c.
  - Write the nibble sum to s[4k+3:4k]. Load c with the adder carry-out.
  - On k=NIB-1: cout ← adder carry-out, ovf ← (carry into the nibble's bit 3) XOR (adder carry-out).
- start while busy=1 is ignored. The latched operands and the in-flight computation are unaffected.
- Input changes on a, b and cin while busy do not affect the result.
- Results (s, cout, ovf) stay stable from done until the next accepted start.
- Arithmetic is modulo 2^WIDTH. The carry out of the top nibble goes only to cout.

## Timing
- Reset values: state=IDLE, busy=0, done=0, s=0, cout=0, ovf=0, counter=0, c=0.
- Reset assertion mid-RUN aborts immediately to the reset values. No done is produced.
- Latency:
  - Start is sampled at edge E0.
  - RUN steps execute at edges E1..E_NIB.
  - done=1 and the result is valid during the cycle after E_NIB. For WIDTH=16 that is 4 cycles after E0.
- Throughput: with start held high, one result every NIB+1 cycles. DONE → RUN is allowed in the same edge, giving back-to-back operation.
- busy rises in the cycle after E0 and falls in the same cycle that done rises.
- done is exactly one cycle wide.

## Structure
- Shared package `nibble_add_pkg`:
  - state enum {IDLE, RUN, DONE}
  - localparam NIB_W=4
  - counter-width function clog2(NIB)
- One sub-module, `nibble_add4`: a combinational 4-bit adder.
  - Inputs: x[3:0], y[3:0], ci.
  - Outputs: sum[3:0], co, c3 (carry into bit 3, used for ovf).
  - Instantiated exactly once; this is the shared resource being sequenced.
- The controller holds the state register, counter, operand and carry registers, and the result register.

## Test plan
- Reset, then start with a=0x0000, b=0x0000, cin=0 → done after 4 cycles, s=0x0000, cout=0, ovf=0.
- a=0x1234, b=0x4321, cin=1 → s=0x5556, cout=0, ovf=0. busy is high for exactly 4 cycles.
- a=0xFFFF, b=0x0001, cin=0 → s=0x0000, cout=1, ovf=0. Then a=0x7FFF, b=0x0001 → s=0x8000, cout=0, ovf=1.
- Start with a=0x00FF, b=0x0001, then pulse start with a=0xAAAA, b=0x5555 while busy → the second start is ignored and the result is s=0x0100.
- Hold start high with operands changing each accepted start → done pulses every 5 cycles, and each s matches the operands latched at its start.
- Assert rst at RUN step 2 → busy, done, s, cout and ovf go to 0 immediately. No done pulse appears. The next start completes normally.

Source files
------------

// File: rtl/nibble_add_pkg.sv
// rtl/nibble_add_pkg.sv - shared types and constants for the nibble-serial adder
package nibble_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIB_W = 4;

  // Bits needed to count n steps; never less than one so a single-nibble
  // configuration still has a legal counter.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/nibble_add4.sv
// rtl/nibble_add4.sv - combinational 4-bit adder shared by the sequencer
module nibble_add4 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       ci,
  output logic [3:0] sum,
  output logic       co,
  output logic       c3
);

  logic [4:0] full;
  logic [3:0] low3;

  // Full nibble sum plus the carry into bit 3 for signed-overflow detection
  always_comb begin
    full = {1'b0, x} + {1'b0, y} + {4'd0, ci};
    low3 = {1'b0, x[2:0]} + {1'b0, y[2:0]} + {3'd0, ci};
    sum  = full[3:0];
    co   = full[4];
    c3   = low3[3];
  end

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// rtl/nibble_serial_add_ctrl.sv - sequences one 4-bit adder over WIDTH-bit operands
module nibble_serial_add_ctrl
  import nibble_add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int NIB   = WIDTH / NIB_W;
  localparam int CNT_W = clog2(NIB);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             c;

  logic             accept;
  logic             last;
  logic [CNT_W+1:0] base;
  logic [3:0]       x_nib;
  logic [3:0]       y_nib;
  logic [3:0]       sum_nib;
  logic             co_nib;
  logic             c3_nib;

  // Start is honoured whenever no computation is in flight; nibble select
  // is derived from the step counter so latched operands never move
  always_comb begin
    accept = start && (state != RUN);
    last   = (cnt == CNT_W'(NIB - 1));
    base   = {cnt, 2'b00};
    x_nib  = a_r[base +: NIB_W];
    y_nib  = b_r[base +: NIB_W];
  end

  nibble_add4 u_add4 (
    .x   (x_nib),
    .y   (y_nib),
    .ci  (c),
    .sum (sum_nib),
    .co  (co_nib),
    .c3  (c3_nib)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: DONE may re-enter RUN directly for back-to-back operation
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded straight from state
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Operand capture on accept, then one nibble per RUN cycle with chained carry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r  <= '0;
      b_r  <= '0;
      c    <= 1'b0;
      cnt  <= '0;
      s    <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else if (accept) begin
      a_r  <= a;
      b_r  <= b;
      c    <= cin;
      cnt  <= '0;
      s    <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else if (state == RUN) begin
      s[base +: NIB_W] <= sum_nib;
      c                <= co_nib;
      if (last) begin
        cnt  <= '0;
        cout <= co_nib;
        ovf  <= c3_nib ^ co_nib;
      end else begin
        cnt  <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb/tb_nibble_serial_add_ctrl.sv - scoreboard bench for the nibble-serial adder
module tb_nibble_serial_add_ctrl;

  typedef struct packed {
    logic [15:0] s;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        busy;
  logic        done;
  logic [15:0] s;
  logic        cout;
  logic        ovf;

  int   tests;
  int   fails;
  exp_t exp_q[$];
  logic prev_done;

  nibble_serial_add_ctrl #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_done = 1'b0;
    end else if (done) begin
      check("done_width", {31'd0, prev_done}, 32'd0);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1, expected no pending result");
      end else begin
        e = exp_q.pop_front();
        check("sum", {16'd0, s}, {16'd0, e.s});
        check("cout", {31'd0, cout}, {31'd0, e.cout});
        check("ovf", {31'd0, ovf}, {31'd0, e.ovf});
      end
      prev_done = 1'b1;
    end else begin
      prev_done = 1'b0;
    end
  end

  task automatic wait_idle();
    int cyc;
    cyc = 0;
    while (busy && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  // One isolated operation; optionally fires a second start mid-flight
  task automatic run_op(input logic [15:0] va, input logic [15:0] vb, input logic vc,
                        input exp_t e, input bit inject);
    int cyc;
    wait_idle();
    a = va; b = vb; cin = vc; start = 1'b1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    cyc = 0;
    while (busy && cyc < 20) begin
      if (inject && cyc == 1) begin
        a = 16'hAAAA; b = 16'h5555; cin = 1'b1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    check("busy_cycles", cyc, 32'd4);
    check("done_at_busy_fall", {31'd0, done}, 32'd1);
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("s_hold", {16'd0, s}, {16'd0, e.s});
    check("cout_hold", {31'd0, cout}, {31'd0, e.cout});
    check("done_low_after", {31'd0, done}, 32'd0);
  endtask

  logic [15:0] bb_a [4];
  logic [15:0] bb_b [4];
  logic        bb_c [4];
  exp_t        bb_e [4];

  initial begin
    int cyc;
    int dcount;
    tests = 0; fails = 0; prev_done = 1'b0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_s", {16'd0, s}, 32'd0);
    check("rst_cout", {31'd0, cout}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    @(posedge clk); #1;

    run_op(16'h0000, 16'h0000, 1'b0, '{s: 16'h0000, cout: 1'b0, ovf: 1'b0}, 1'b0);
    run_op(16'h1234, 16'h4321, 1'b1, '{s: 16'h5556, cout: 1'b0, ovf: 1'b0}, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, '{s: 16'h0000, cout: 1'b1, ovf: 1'b0}, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, '{s: 16'h8000, cout: 1'b0, ovf: 1'b1}, 1'b0);
    run_op(16'h00FF, 16'h0001, 1'b0, '{s: 16'h0100, cout: 1'b0, ovf: 1'b0}, 1'b1);

    // Back-to-back with start held high
    bb_a[0] = 16'h8000; bb_b[0] = 16'h8000; bb_c[0] = 1'b0; bb_e[0] = '{s: 16'h0000, cout: 1'b1, ovf: 1'b1};
    bb_a[1] = 16'h1111; bb_b[1] = 16'h2222; bb_c[1] = 1'b1; bb_e[1] = '{s: 16'h3334, cout: 1'b0, ovf: 1'b0};
    bb_a[2] = 16'hABCD; bb_b[2] = 16'h1234; bb_c[2] = 1'b0; bb_e[2] = '{s: 16'hBE01, cout: 1'b0, ovf: 1'b0};
    bb_a[3] = 16'h7000; bb_b[3] = 16'h7000; bb_c[3] = 1'b0; bb_e[3] = '{s: 16'hE000, cout: 1'b0, ovf: 1'b1};
    wait_idle();
    a = bb_a[0]; b = bb_b[0]; cin = bb_c[0]; start = 1'b1;
    exp_q.push_back(bb_e[0]);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      cyc = 0;
      do begin
        @(posedge clk); #1;
        cyc++;
      end while (!done && cyc < 20);
      check("b2b_period", cyc + 1, 32'd5);
      if (i < 3) begin
        a = bb_a[i+1]; b = bb_b[i+1]; cin = bb_c[i+1];
        exp_q.push_back(bb_e[i+1]);
      end else begin
        start = 1'b0;
      end
    end
    @(posedge clk); #1;

    // Reset aborts a computation partway through
    wait_idle();
    a = 16'h1234; b = 16'h4321; cin = 1'b1; start = 1'b1;
    exp_q.push_back('{s: 16'h5556, cout: 1'b0, ovf: 1'b0});
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_s", {16'd0, s}, 32'd0);
    check("abort_cout", {31'd0, cout}, 32'd0);
    check("abort_ovf", {31'd0, ovf}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    dcount = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done) dcount++;
    end
    check("no_done_after_abort", dcount, 32'd0);
    run_op(16'h0F0F, 16'hF0F0, 1'b1, '{s: 16'h0000, cout: 1'b1, ovf: 1'b0}, 1'b0);

    cyc = 0;
    while (exp_q.size() != 0 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
